lieat_dcache_axi_rsp: RTL and testbench

- Single-port AXI-lite-style responder (slave) for the data-cache AXI master port of the execute unit.
- Accepts single-beat reads and writes on the dcache_axi_* channel set: 32-bit address, 64-bit data, 8-bit strobe, no IDs, no bursts.
- Serves accesses from an internal 64-bit-word memory with programmable read/write latency.
- Used as the simulation/ASIC scratch memory behind the dcache and as the protocol counterpart for verification of the master side.

---
 rtl/lieat_dcache_axi_rsp.sv | 167 ++++++++++++++++
 tb/tb_lieat_dcache_axi_rsp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_dcache_axi_rsp.sv
// rtl/lieat_dcache_axi_rsp.sv - single-beat AXI-lite-style memory responder behind the dcache master port
module lieat_dcache_axi_rsp #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          MEM_DEPTH = 1024,
    parameter int          RD_LAT    = 1,
    parameter int          WR_LAT    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dcache_axi_arvalid,
    output logic        dcache_axi_arready,
    input  logic [31:0] dcache_axi_araddr,
    input  logic [2:0]  dcache_axi_arsize,
    output logic        dcache_axi_rvalid,
    input  logic        dcache_axi_rready,
    output logic [63:0] dcache_axi_rdata,
    input  logic        dcache_axi_awvalid,
    output logic        dcache_axi_awready,
    input  logic [31:0] dcache_axi_awaddr,
    input  logic [2:0]  dcache_axi_awsize,
    input  logic        dcache_axi_wvalid,
    output logic        dcache_axi_wready,
    input  logic [63:0] dcache_axi_wdata,
    input  logic [7:0]  dcache_axi_wstrb,
    output logic        dcache_axi_bvalid,
    input  logic        dcache_axi_bready,
    output logic [1:0]  dcache_axi_bresp
);
    localparam int          IW        = $clog2(MEM_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH) << 3;

    typedef enum logic [2:0] {IDLE, RLAT, RRSP, WLAT, BRSP} state_t;

    state_t      state;
    logic        init;
    logic        aw_got;
    logic        w_got;
    logic [31:0] aw_addr;
    logic [2:0]  aw_size;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic [31:0] ar_addr;
    logic [2:0]  ar_size;
    logic [3:0]  cnt;
    logic [63:0] mem [MEM_DEPTH];

    logic        idle_ok;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        mem_we;
    logic        size_unused;

    function automatic logic in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return (a >= ADDR_BASE) && ({1'b0, off} < MEM_BYTES);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return off[IW+2:3];
    endfunction

    assign idle_ok            = init && (state == IDLE);
    assign dcache_axi_awready = idle_ok && !aw_got;
    assign dcache_axi_wready  = idle_ok && !w_got;
    // Writes win: AR is held off whenever any write beat is pending or offered.
    assign dcache_axi_arready = idle_ok && !aw_got && !w_got
                                && !dcache_axi_awvalid && !dcache_axi_wvalid;

    assign aw_hs = dcache_axi_awvalid && dcache_axi_awready;
    assign w_hs  = dcache_axi_wvalid && dcache_axi_wready;
    assign ar_hs = dcache_axi_arvalid && dcache_axi_arready;

    assign mem_we      = (state == WLAT) && (cnt == 4'd0) && in_rng(aw_addr);
    assign size_unused = ^{aw_size, ar_size};

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (w_strb[b]) begin
                    mem[word_idx(aw_addr)][8*b +: 8] <= w_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            init              <= 1'b0;
            aw_got            <= 1'b0;
            w_got             <= 1'b0;
            aw_addr           <= '0;
            aw_size           <= '0;
            w_data            <= '0;
            w_strb            <= '0;
            ar_addr           <= '0;
            ar_size           <= '0;
            cnt               <= '0;
            dcache_axi_rvalid <= 1'b0;
            dcache_axi_rdata  <= '0;
            dcache_axi_bvalid <= 1'b0;
            dcache_axi_bresp  <= '0;
        end else begin
            init <= 1'b1;
            if (aw_hs) begin
                aw_got  <= 1'b1;
                aw_addr <= dcache_axi_awaddr;
                aw_size <= dcache_axi_awsize;
            end
            if (w_hs) begin
                w_got  <= 1'b1;
                w_data <= dcache_axi_wdata;
                w_strb <= dcache_axi_wstrb;
            end
            case (state)
                IDLE: begin
                    if (aw_got && w_got) begin
                        state  <= WLAT;
                        cnt    <= 4'(WR_LAT - 1);
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                    end else if (ar_hs) begin
                        state   <= RLAT;
                        cnt     <= 4'(RD_LAT - 1);
                        ar_addr <= dcache_axi_araddr;
                        ar_size <= dcache_axi_arsize;
                    end
                end
                WLAT: begin
                    if (cnt == 4'd0) begin
                        dcache_axi_bvalid <= 1'b1;
                        dcache_axi_bresp  <= in_rng(aw_addr) ? 2'b00 : 2'b10;
                        state             <= BRSP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                BRSP: begin
                    if (dcache_axi_bready) begin
                        dcache_axi_bvalid <= 1'b0;
                        state             <= IDLE;
                    end
                end
                RLAT: begin
                    if (cnt == 4'd0) begin
                        dcache_axi_rdata  <= in_rng(ar_addr) ? mem[word_idx(ar_addr)] : 64'h0;
                        dcache_axi_rvalid <= 1'b1;
                        state             <= RRSP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RRSP: begin
                    if (dcache_axi_rready) begin
                        dcache_axi_rvalid <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lieat_dcache_axi_rsp.sv
// tb/tb_lieat_dcache_axi_rsp.sv - randomized directed bench with a word-array reference model
module tb_lieat_dcache_axi_rsp;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          DEPTH  = 64;
    localparam int          RD_LAT = 3;
    localparam int          WR_LAT = 2;
    localparam int          BUDGET = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [2:0]  arsize = 3'd3;
    logic        rvalid, rready = 1'b0;
    logic [63:0] rdata;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [2:0]  awsize = 3'd3;
    logic        wvalid = 1'b0, wready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;

    int vectors = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = 0;
    logic [63:0] model [DEPTH];

    lieat_dcache_axi_rsp #(
        .ADDR_BASE(BASE), .MEM_DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clock(clk), .reset(rst_n),
        .dcache_axi_arvalid(arvalid), .dcache_axi_arready(arready),
        .dcache_axi_araddr(araddr), .dcache_axi_arsize(arsize),
        .dcache_axi_rvalid(rvalid), .dcache_axi_rready(rready), .dcache_axi_rdata(rdata),
        .dcache_axi_awvalid(awvalid), .dcache_axi_awready(awready),
        .dcache_axi_awaddr(awaddr), .dcache_axi_awsize(awsize),
        .dcache_axi_wvalid(wvalid), .dcache_axi_wready(wready),
        .dcache_axi_wdata(wdata), .dcache_axi_wstrb(wstrb),
        .dcache_axi_bvalid(bvalid), .dcache_axi_bready(bready), .dcache_axi_bresp(bresp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint unsigned x = a;
        return (x >= longint'(BASE)) && (x < longint'(BASE) + DEPTH * 8);
    endfunction

    function automatic int widx(input logic [31:0] a);
        longint unsigned x = a;
        return int'((x - longint'(BASE)) / 8);
    endfunction

    function automatic logic [31:0] rnd_addr();
        return BASE + 32'($urandom_range(0, DEPTH - 1) * 8) + 32'($urandom_range(0, 7));
    endfunction

    task automatic wait_ready(input string tag, ref logic rdy);
        int n = 0;
        #1;
        while (!rdy && n < BUDGET) begin
            @(negedge clk); #1; n++;
        end
        if (n >= BUDGET) check({tag, " ready timeout"}, 0, 1);
    endtask

    task automatic send_aw(input logic [31:0] a);
        awvalid = 1'b1; awaddr = a;
        wait_ready("aw", awready);
        @(posedge clk); #1; hs_cyc = cyc;
        @(negedge clk); awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s);
        wvalid = 1'b1; wdata = d; wstrb = s;
        wait_ready("w", wready);
        @(posedge clk); #1; hs_cyc = cyc;
        @(negedge clk); wvalid = 1'b0;
    endtask

    task automatic finish_b(input logic [1:0] exp_resp, input int bhold);
        int n = 0;
        @(negedge clk);
        while (!bvalid && n < BUDGET) begin @(negedge clk); n++; end
        check("b latency", 64'(cyc - hs_cyc), 64'(WR_LAT + 1));
        check("bresp", 64'(bresp), 64'(exp_resp));
        for (int i = 0; i < bhold; i++) begin
            @(negedge clk);
            check("b hold", {61'd0, bvalid, bresp}, {61'd0, 1'b1, exp_resp});
            check("b hold readies", {61'd0, arready, awready, wready}, 64'd0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("b after hs", {62'd0, bvalid, awready & wready}, 64'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                      input int order, input int bhold);
        if (order == 1) begin
            send_w(d, s); send_aw(a);
        end else if (order == 2) begin
            send_aw(a); send_w(d, s);
        end else begin
            awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
            wait_ready("aww", awready);
            @(posedge clk); #1; hs_cyc = cyc;
            @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        end
        if (in_rng(a))
            for (int b = 0; b < 8; b++) if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
        finish_b(in_rng(a) ? 2'b00 : 2'b10, bhold);
    endtask

    task automatic finish_r(input logic [31:0] a, input int t, input int hold);
        int n = 0;
        logic [63:0] exp_d;
        exp_d = in_rng(a) ? model[widx(a)] : 64'h0;
        while (!rvalid && n < BUDGET) begin @(negedge clk); n++; end
        check("r latency", 64'(cyc - t), 64'(RD_LAT));
        check("rdata", rdata, exp_d);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r hold", {rvalid, rdata[62:0]}, {1'b1, exp_d[62:0]});
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("r after hs", 64'(rvalid), 64'd0);
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input int hold);
        int t;
        arvalid = 1'b1; araddr = a; arsize = 3'($urandom_range(0, 3));
        wait_ready("ar", arready);
        @(posedge clk); #1; t = cyc;
        @(negedge clk); arvalid = 1'b0;
        finish_r(a, t, hold);
    endtask

    initial begin
        int t, bad;
        logic [31:0] a;
        logic [63:0] d;

        repeat (3) @(negedge clk);
        check("reset outputs", {rvalid, bvalid, bresp, rdata[59:0]}, 64'd0);
        check("reset readies", {61'd0, arready, awready, wready}, 64'd0);
        rst_n = 1'b1; #1;
        check("init readies", {61'd0, arready, awready, wready}, 64'd0);
        @(posedge clk); #1;
        check("post-init readies", {61'd0, arready, awready, wready}, 64'd7);
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++)
            wr(BASE + 32'(i * 8), {$urandom, $urandom}, 8'hFF, $urandom_range(0, 2), 0);

        wr(32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 0);
        rd(32'h8000_0014, 4);

        wr(32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2, 0);
        wr(32'h8000_0000, 64'h0, 8'h0F, 1, 0);
        rd(32'h8000_0000, 0);
        check("masked word", model[0], 64'hFFFF_FFFF_0000_0000);

        wr(32'h8000_0008, {$urandom, $urandom}, 8'h00, 0, 0);
        rd(32'h8000_0008, 1);

        wr(32'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 0);
        rd(BASE + 32'((DEPTH - 1) * 8), 0);
        wr(BASE + 32'(DEPTH * 8), 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2, 0);
        rd(BASE, 0);
        rd(BASE + 32'(DEPTH * 8), 0);

        wr(rnd_addr(), {$urandom, $urandom}, 8'($urandom), 0, 10);

        // Priority: all three valids together, AR must wait out the whole write.
        a = BASE + 32'h100; d = {$urandom, $urandom};
        arvalid = 1'b1; araddr = a; awvalid = 1'b1; awaddr = a;
        wvalid = 1'b1; wdata = d; wstrb = 8'hFF; #1;
        check("prio readies", {61'd0, arready, awready, wready}, 64'd3);
        @(posedge clk); #1; hs_cyc = cyc;
        @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;
        model[widx(a)] = d;
        bad = 0;
        while (!bvalid && bad < BUDGET) begin
            if (arready) bad = BUDGET;
            @(negedge clk); bad++;
        end
        check("prio ar blocked", 64'(bad < BUDGET), 64'd1);
        bready = 1'b1;
        @(posedge clk); #1; bready = 1'b0;
        check("prio ar after b", 64'(arready), 64'd1);
        @(posedge clk); #1; t = cyc;
        @(negedge clk); arvalid = 1'b0;
        finish_r(a, t, 0);

        // Reset while the read is still counting down.
        a = rnd_addr();
        arvalid = 1'b1; araddr = a;
        wait_ready("ar rst", arready);
        @(posedge clk); #1;
        @(negedge clk); arvalid = 1'b0;
        @(negedge clk); rst_n = 1'b0; #1;
        check("rst mid-read", {62'd0, rvalid, arready}, 64'd0);
        bad = 0;
        repeat (4) begin @(negedge clk); bad += int'(rvalid); end
        check("rst rvalid low", 64'(bad), 64'd0);
        rst_n = 1'b1; #1;
        check("rst init readies", {61'd0, arready, awready, wready}, 64'd0);
        @(posedge clk); #1;
        check("rst readies back", 64'(arready), 64'd1);
        @(negedge clk);
        rd(a, 1);

        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom : rnd_addr();
            if ($urandom_range(0, 1) == 0)
                wr(a, {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
            else
                rd(a, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
